tw_cmd_sequencer: RTL and testbench
===================================

// Module: tw_cmd_sequencer
// PURPOSE
//  Host command sequencer between the FTDI byte controller and the 3-wire master.
//  Parses USB command packets (cmd, address, data), issues burst 3-wire transactions with optional address auto-increment.
//  Returns read data or a write status byte to the host.
//  Watchdog aborts stalled packets.
// PARAMETERS
//  ADDRESS_BITS    8        3-wire address width, 1..16; AB = ceil(ADDRESS_BITS/8) address bytes
//  DATA_BITS       8        3-wire data width, 1..16; DB = ceil(DATA_BITS/8) data bytes per word
//  TIMEOUT_CYCLES  1000000  max idle in_clk cycles between host bytes inside a packet
// PORTS
//  in_clk          in   1   system clock, one clock domain
//  in_rst_n        in   1   asynchronous active-low reset
//  in_rx_hsk_req   in   1   FTDI rx byte valid (4-phase req)
//  out_rx_hsk_ack  out  1   rx byte accepted (4-phase ack)
//  in_rx_data      in   8   rx byte, stable while in_rx_hsk_req=1
//  out_rx_en       out  1   sequencer can accept host bytes
//  out_tx_hsk_req  out  1   tx byte valid (4-phase req)
//  in_tx_hsk_ack   in   1   FTDI accepted tx byte
//  out_tx_data     out  8   tx byte, stable while out_tx_hsk_req=1
//  out_tw_start    out  1   1-cycle pulse: start one 3-wire transfer
//  out_tw_rnw      out  1   1=read, 0=write; valid with out_tw_start
//  out_tw_addr     out  ADDRESS_BITS  transfer address
//  out_tw_wdata    out  DATA_BITS     write data
//  in_tw_done      in   1   1-cycle pulse: 3-wire transfer complete
//  in_tw_rdata     in   DATA_BITS     read data, valid with in_tw_done
//  out_busy        out  1   packet in progress (state != IDLE)
//  out_err         out  1   sticky timeout flag, cleared by next accepted cmd byte
// BEHAVIOUR
//  Reset: all outputs 0 except out_rx_en=1; state IDLE; counters and address 0.
//  Cmd byte: [7] RNW, [6] INC (address +1 per word), [5:0] LEN-1 (1..64 words).
//  Packet: cmd, AB address bytes, then (write only) LEN*DB data bytes.
//  Multi-byte fields are MSB first; bits above the field width are discarded.
//  Rx handshake: req=1 -> latch data, ack=1 next cycle; hold ack until req=0, then ack=0.
//  Next byte is not accepted until ack=0.
//  Tx handshake: drive data and req=1; on ack=1 drop req; no new req until ack=0.
//  out_rx_en=1 only in IDLE, GET_ADDR and GET_DATA.
//  FSM: IDLE -> GET_ADDR on cmd byte.
//  GET_ADDR -> TW_START after AB bytes for a read; -> GET_DATA for a write.
//  GET_DATA -> TW_START after DB bytes.
//  TW_START: single start pulse -> TW_WAIT.
//  TW_WAIT on in_tw_done: read -> SEND_DATA (DB bytes of in_tw_rdata, MSB first).
//  TW_WAIT on in_tw_done, write: more words -> GET_DATA; last word -> SEND_STATUS.
//  SEND_DATA: more words -> TW_START; last word -> IDLE.
//  SEND_STATUS: tx 0x5A -> IDLE.
//  Latency: out_tw_start asserts 1 cycle after ack rises on the last operand byte.
//  For reads, start asserts 1 cycle after the tx ack drops on the previous word.
//  INC=1: address += 1 after each in_tw_done, wrapping modulo 2^ADDRESS_BITS. INC=0: address constant.
//  Word counter counts down from LEN-1; the last word is counter==0.
//  Watchdog runs only in GET_ADDR and GET_DATA; it reloads on each rx ack.
//  Watchdog expiry: out_err=1 and FSM -> IDLE; a partial write word is not issued.
//  in_tw_done outside TW_WAIT is ignored.
//  in_rx_hsk_req outside rx states is left un-acked; the byte is held off by out_rx_en=0.
//  A reset mid-packet or mid-transfer aborts at once; no tw_start or tx req after the reset edge.
// TESTING
//  Single write: 0x00,0x12,0xAB -> one tw_start with rnw=0, addr=0x12, wdata=0xAB; tx 0x5A; out_busy=0 after.
//  Read burst INC: 0xC2,0xFE with rdata 1,2,3 -> addrs 0xFE,0xFF,0x00 (wrap); tx 0x01,0x02,0x03.
//  Write burst no-INC, DATA_BITS=16: 0x01,0x40,0x12,0x34,0x56,0x78 -> writes 0x1234 then 0x5678, both to addr 0x40; one 0x5A.
//  Timeout, TIMEOUT_CYCLES=100: 0x00 then stall 101 cycles -> out_err=1, IDLE, no tw_start; next cmd clears out_err.
//  Handshake stress: slow rx req release and tx ack delays of 0..20 cycles -> no lost or duplicated bytes; tx data stable while req=1.
//  Reset asserted in TW_WAIT -> outputs at reset values; a later in_tw_done is ignored; a new packet works.

Source files
------------

// File: rtl/tw_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tw_cmd_sequencer
//   Host command sequencer between the FTDI byte controller and the 3-wire
//   master. Parses host packets (cmd, address, data), issues burst 3-wire
//   transfers with optional address auto-increment, and returns read data or
//   a write status byte (0x5A). A watchdog aborts packets that stall between
//   host bytes.
//
// Ports
//   in_clk, in_rst_n     clock, asynchronous active-low reset
//   in_rx_hsk_req        host byte valid (4-phase req)
//   out_rx_hsk_ack       host byte accepted (4-phase ack)
//   in_rx_data[7:0]      host byte, stable while req=1
//   out_rx_en            sequencer can accept host bytes
//   out_tx_hsk_req       tx byte valid (4-phase req)
//   in_tx_hsk_ack        tx byte accepted
//   out_tx_data[7:0]     tx byte, stable while req=1
//   out_tw_start         1-cycle pulse, start one 3-wire transfer
//   out_tw_rnw           1=read, 0=write
//   out_tw_addr          transfer address
//   out_tw_wdata         write data
//   in_tw_done           1-cycle pulse, transfer complete
//   in_tw_rdata          read data, valid with in_tw_done
//   out_busy             packet in progress
//   out_err              sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module tw_cmd_sequencer #(
   parameter int unsigned ADDRESS_BITS   = 8,
   parameter int unsigned DATA_BITS      = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                    in_clk,
   input  logic                    in_rst_n,
   input  logic                    in_rx_hsk_req,
   output logic                    out_rx_hsk_ack,
   input  logic [7:0]              in_rx_data,
   output logic                    out_rx_en,
   output logic                    out_tx_hsk_req,
   input  logic                    in_tx_hsk_ack,
   output logic [7:0]              out_tx_data,
   output logic                    out_tw_start,
   output logic                    out_tw_rnw,
   output logic [ADDRESS_BITS-1:0] out_tw_addr,
   output logic [DATA_BITS-1:0]    out_tw_wdata,
   input  logic                    in_tw_done,
   input  logic [DATA_BITS-1:0]    in_tw_rdata,
   output logic                    out_busy,
   output logic                    out_err
);

   localparam int unsigned AB   = (ADDRESS_BITS + 7) / 8;
   localparam int unsigned DB   = (DATA_BITS + 7) / 8;
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]  STATUS_OK = 8'h5A;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_ADDR,
      S_GET_DATA,
      S_TW_START,
      S_TW_WAIT,
      S_SEND_DATA,
      S_SEND_STATUS
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_rnw, w_rnw_nxt;
   logic                    r_inc, w_inc_nxt;
   logic [5:0]              r_wcnt, w_wcnt_nxt;
   logic [1:0]              r_bcnt, w_bcnt_nxt;
   logic [ADDRESS_BITS-1:0] r_addr, w_addr_nxt;
   logic [DATA_BITS-1:0]    r_wdata, w_wdata_nxt;
   logic [DATA_BITS-1:0]    r_rdata, w_rdata_nxt;
   logic                    r_tx_req, w_tx_req_nxt;
   logic                    r_tx_hold, w_tx_hold_nxt;
   logic [7:0]              r_tx_data, w_tx_data_nxt;
   logic                    r_err, w_err_nxt;

   logic                    r_rx_ack;
   logic                    r_rx_vld;
   logic [7:0]              r_rx_byte;
   logic [WD_W-1:0]         r_wd;

   logic                    w_rx_state;
   logic                    w_rx_take;
   logic                    w_wd_run;
   logic                    w_wd_expire;
   logic                    w_tx_done;
   logic                    w_tx_free;
   logic [ADDRESS_BITS-1:0] w_addr_sh;
   logic [DATA_BITS-1:0]    w_wdata_sh;
   logic [8*DB-1:0]         w_rd_pad;
   logic [7:0]              w_rd_byte;

   // ---------------------------------------------------------------------------
   // Rx 4-phase handshake. The byte is latched when ack rises and handed to
   // the FSM one cycle later (r_rx_vld), so ack drops independently of state.
   // ---------------------------------------------------------------------------
   assign w_rx_state = (r_state == S_IDLE) || (r_state == S_GET_ADDR) ||
                       (r_state == S_GET_DATA);
   assign w_rx_take  = w_rx_state && in_rx_hsk_req && !r_rx_ack;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_rx_ack  <= 1'b0;
         r_rx_vld  <= 1'b0;
         r_rx_byte <= '0;
      end else begin
         r_rx_vld <= w_rx_take;
         if (w_rx_take) begin
            r_rx_byte <= in_rx_data;
            r_rx_ack  <= 1'b1;
         end else if (!in_rx_hsk_req) begin
            r_rx_ack  <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Watchdog: counts idle cycles in the operand-gathering states, reloads on
   // every accepted byte. Expiry is suppressed in the cycle a byte is taken so
   // a latched byte is always consumed in the state that accepted it.
   // ---------------------------------------------------------------------------
   assign w_wd_run    = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
   assign w_wd_expire = w_wd_run && !w_rx_take &&
                        (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_wd <= '0;
      end else if (!w_wd_run || w_rx_take || w_wd_expire) begin
         r_wd <= '0;
      end else begin
         r_wd <= r_wd + WD_W'(1);
      end
   end

   // Multi-byte fields shift in MSB first; bits above the field width fall off.
   assign w_addr_sh  = ADDRESS_BITS'({r_addr, r_rx_byte});
   assign w_wdata_sh = DATA_BITS'({r_wdata, r_rx_byte});

   // Read data is returned MSB byte first.
   assign w_rd_pad  = (8*DB)'(r_rdata);
   assign w_rd_byte = 8'(w_rd_pad >> (8 * (DB - 1 - int'(r_bcnt))));

   // A new tx byte may only be launched when the previous handshake has fully
   // returned to zero.
   assign w_tx_free = !r_tx_req && !r_tx_hold && !in_tx_hsk_ack;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state   <= S_IDLE;
         r_rnw     <= 1'b0;
         r_inc     <= 1'b0;
         r_wcnt    <= '0;
         r_bcnt    <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_tx_req  <= 1'b0;
         r_tx_hold <= 1'b0;
         r_tx_data <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rnw     <= w_rnw_nxt;
         r_inc     <= w_inc_nxt;
         r_wcnt    <= w_wcnt_nxt;
         r_bcnt    <= w_bcnt_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_rdata   <= w_rdata_nxt;
         r_tx_req  <= w_tx_req_nxt;
         r_tx_hold <= w_tx_hold_nxt;
         r_tx_data <= w_tx_data_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and datapath updates
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_rnw_nxt     = r_rnw;
      w_inc_nxt     = r_inc;
      w_wcnt_nxt    = r_wcnt;
      w_bcnt_nxt    = r_bcnt;
      w_addr_nxt    = r_addr;
      w_wdata_nxt   = r_wdata;
      w_rdata_nxt   = r_rdata;
      w_tx_req_nxt  = r_tx_req;
      w_tx_hold_nxt = r_tx_hold;
      w_tx_data_nxt = r_tx_data;
      w_err_nxt     = r_err;
      w_tx_done     = 1'b0;

      // Tx byte engine: req -> ack seen (drop req) -> ack low (byte done).
      if (r_tx_req) begin
         if (in_tx_hsk_ack) begin
            w_tx_req_nxt  = 1'b0;
            w_tx_hold_nxt = 1'b1;
         end
      end else if (r_tx_hold) begin
         if (!in_tx_hsk_ack) begin
            w_tx_hold_nxt = 1'b0;
            w_tx_done     = 1'b1;
         end
      end

      case (r_state)
         S_IDLE: begin
            if (r_rx_vld) begin
               w_rnw_nxt   = r_rx_byte[7];
               w_inc_nxt   = r_rx_byte[6];
               w_wcnt_nxt  = r_rx_byte[5:0];
               w_bcnt_nxt  = '0;
               w_err_nxt   = 1'b0;
               w_state_nxt = S_GET_ADDR;
            end
         end

         S_GET_ADDR: begin
            if (r_rx_vld) begin
               w_addr_nxt = w_addr_sh;
               if (r_bcnt == 2'(AB - 1)) begin
                  w_bcnt_nxt  = '0;
                  w_state_nxt = r_rnw ? S_TW_START : S_GET_DATA;
               end else begin
                  w_bcnt_nxt = r_bcnt + 2'd1;
               end
            end else if (w_wd_expire) begin
               w_err_nxt   = 1'b1;
               w_bcnt_nxt  = '0;
               w_state_nxt = S_IDLE;
            end
         end

         S_GET_DATA: begin
            if (r_rx_vld) begin
               w_wdata_nxt = w_wdata_sh;
               if (r_bcnt == 2'(DB - 1)) begin
                  w_bcnt_nxt  = '0;
                  w_state_nxt = S_TW_START;
               end else begin
                  w_bcnt_nxt = r_bcnt + 2'd1;
               end
            end else if (w_wd_expire) begin
               w_err_nxt   = 1'b1;
               w_bcnt_nxt  = '0;
               w_state_nxt = S_IDLE;
            end
         end

         S_TW_START: begin
            w_state_nxt = S_TW_WAIT;
         end

         // Reads count words down after the data is returned; writes count
         // down here because the next data bytes follow directly.
         S_TW_WAIT: begin
            if (in_tw_done) begin
               if (r_inc) begin
                  w_addr_nxt = r_addr + ADDRESS_BITS'(1);
               end
               w_bcnt_nxt = '0;
               if (r_rnw) begin
                  w_rdata_nxt = in_tw_rdata;
                  w_state_nxt = S_SEND_DATA;
               end else if (r_wcnt == '0) begin
                  w_state_nxt = S_SEND_STATUS;
               end else begin
                  w_wcnt_nxt  = r_wcnt - 6'd1;
                  w_state_nxt = S_GET_DATA;
               end
            end
         end

         S_SEND_DATA: begin
            if (w_tx_done) begin
               if (r_bcnt == 2'(DB - 1)) begin
                  w_bcnt_nxt = '0;
                  if (r_wcnt == '0) begin
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_wcnt_nxt  = r_wcnt - 6'd1;
                     w_state_nxt = S_TW_START;
                  end
               end else begin
                  w_bcnt_nxt = r_bcnt + 2'd1;
               end
            end else if (w_tx_free) begin
               w_tx_req_nxt  = 1'b1;
               w_tx_data_nxt = w_rd_byte;
            end
         end

         S_SEND_STATUS: begin
            if (w_tx_done) begin
               w_state_nxt = S_IDLE;
            end else if (w_tx_free) begin
               w_tx_req_nxt  = 1'b1;
               w_tx_data_nxt = STATUS_OK;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign out_rx_hsk_ack = r_rx_ack;
   assign out_rx_en      = w_rx_state;
   assign out_tx_hsk_req = r_tx_req;
   assign out_tx_data    = r_tx_data;
   assign out_tw_start   = (r_state == S_TW_START);
   assign out_tw_rnw     = r_rnw;
   assign out_tw_addr    = r_addr;
   assign out_tw_wdata   = r_wdata;
   assign out_busy       = (r_state != S_IDLE);
   assign out_err        = r_err;

endmodule

// File: tb/tb_tw_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tw_cmd_sequencer
//   Directed-vector bench. Two sequencer instances: u_dut8 (8-bit address and
//   data, short watchdog) and u_dut16 (16-bit data). One shared set of host,
//   tx and 3-wire stimulus signals is steered to the instance chosen by sel.
// -----------------------------------------------------------------------------
module tb_tw_cmd_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned sel = 0;

   // shared stimulus
   logic        rx_req   = 1'b0;
   logic [7:0]  rx_data  = '0;
   logic        tx_ack   = 1'b0;
   logic        tw_done  = 1'b0;
   logic [15:0] tw_rdata = '0;

   // instance A: ADDRESS_BITS=8, DATA_BITS=8, TIMEOUT_CYCLES=100
   logic       a_rx_ack, a_rx_en, a_tx_req, a_tw_start, a_tw_rnw, a_busy, a_err;
   logic [7:0] a_tx_data, a_tw_addr, a_tw_wdata;
   // instance B: ADDRESS_BITS=8, DATA_BITS=16, TIMEOUT_CYCLES=1000
   logic        b_rx_ack, b_rx_en, b_tx_req, b_tw_start, b_tw_rnw, b_busy, b_err;
   logic [7:0]  b_tx_data, b_tw_addr;
   logic [15:0] b_tw_wdata;

   tw_cmd_sequencer #(.ADDRESS_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(100)) u_dut8 (
      .in_clk(clk), .in_rst_n(rst_n),
      .in_rx_hsk_req(rx_req && sel == 0), .out_rx_hsk_ack(a_rx_ack),
      .in_rx_data(rx_data), .out_rx_en(a_rx_en),
      .out_tx_hsk_req(a_tx_req), .in_tx_hsk_ack(tx_ack && sel == 0),
      .out_tx_data(a_tx_data),
      .out_tw_start(a_tw_start), .out_tw_rnw(a_tw_rnw),
      .out_tw_addr(a_tw_addr), .out_tw_wdata(a_tw_wdata),
      .in_tw_done(tw_done && sel == 0), .in_tw_rdata(tw_rdata[7:0]),
      .out_busy(a_busy), .out_err(a_err)
   );

   tw_cmd_sequencer #(.ADDRESS_BITS(8), .DATA_BITS(16), .TIMEOUT_CYCLES(1000)) u_dut16 (
      .in_clk(clk), .in_rst_n(rst_n),
      .in_rx_hsk_req(rx_req && sel == 1), .out_rx_hsk_ack(b_rx_ack),
      .in_rx_data(rx_data), .out_rx_en(b_rx_en),
      .out_tx_hsk_req(b_tx_req), .in_tx_hsk_ack(tx_ack && sel == 1),
      .out_tx_data(b_tx_data),
      .out_tw_start(b_tw_start), .out_tw_rnw(b_tw_rnw),
      .out_tw_addr(b_tw_addr), .out_tw_wdata(b_tw_wdata),
      .in_tw_done(tw_done && sel == 1), .in_tw_rdata(tw_rdata),
      .out_busy(b_busy), .out_err(b_err)
   );

   // selected-instance view
   logic        m_rx_ack, m_rx_en, m_tx_req, m_tw_start, m_tw_rnw, m_busy, m_err;
   logic [7:0]  m_tx_data, m_tw_addr;
   logic [15:0] m_tw_wdata;
   assign m_rx_ack   = sel == 1 ? b_rx_ack   : a_rx_ack;
   assign m_rx_en    = sel == 1 ? b_rx_en    : a_rx_en;
   assign m_tx_req   = sel == 1 ? b_tx_req   : a_tx_req;
   assign m_tx_data  = sel == 1 ? b_tx_data  : a_tx_data;
   assign m_tw_start = sel == 1 ? b_tw_start : a_tw_start;
   assign m_tw_rnw   = sel == 1 ? b_tw_rnw   : a_tw_rnw;
   assign m_tw_addr  = sel == 1 ? b_tw_addr  : a_tw_addr;
   assign m_tw_wdata = sel == 1 ? b_tw_wdata : {8'h00, a_tw_wdata};
   assign m_busy     = sel == 1 ? b_busy     : a_busy;
   assign m_err      = sel == 1 ? b_err      : a_err;

   int n_vec  = 0;
   int n_miss = 0;
   int n_tmo  = 0;
   int n_unstable = 0;
   int n_start = 0;
   int done_dly = 2;
   bit stress = 1'b0;

   logic [32:0] st_q[$];   // {rnw, addr[15:0], wdata[15:0]}
   logic [15:0] rd_q[$];
   logic [7:0]  tx_q[$];

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // 3-wire slave model: records each start and returns done after done_dly
   always @(negedge clk) if (m_tw_start) n_start++;

   initial begin
      forever begin
         @(negedge clk);
         if (m_tw_start && rst_n) begin
            st_q.push_back({m_tw_rnw, 8'h00, m_tw_addr, m_tw_wdata});
            repeat (done_dly) @(negedge clk);
            tw_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0000;
            tw_done = 1'b1;
            @(negedge clk);
            tw_done = 1'b0;
         end
      end
   end

   // tx host model: captures bytes, checks stability while req is high
   initial begin
      logic [7:0] cap;
      int d;
      int t;
      forever begin
         @(negedge clk);
         if (m_tx_req && !tx_ack) begin
            cap = m_tx_data;
            tx_q.push_back(cap);
            d = stress ? int'($urandom_range(0, 20)) : 0;
            repeat (d) begin
               @(negedge clk);
               if (m_tx_data !== cap || !m_tx_req) n_unstable++;
            end
            tx_ack = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (m_tx_req && t < 200);
            if (m_tx_req) n_tmo++;
            d = stress ? int'($urandom_range(0, 20)) : 0;
            repeat (d) begin
               @(negedge clk);
               if (m_tx_req) n_unstable++;
            end
            tx_ack = 1'b0;
         end
      end
   end

   // host rx driver; lat_chk verifies tw_start follows the ack rise by 1 cycle
   task automatic send_byte(input logic [7:0] b, input bit lat_chk);
      int t;
      int hold;
      t = 0;
      while (m_rx_ack && t < 200) begin @(negedge clk); t++; end
      rx_data = b;
      rx_req  = 1'b1;
      t = 0;
      while (!m_rx_ack && t < 200) begin @(negedge clk); t++; end
      if (!m_rx_ack) n_tmo++;
      if (lat_chk) begin
         check("lat_pre", m_tw_start, 1'b0);
         @(negedge clk);
         check("lat_start", m_tw_start, 1'b1);
      end
      hold = stress ? int'($urandom_range(0, 20)) : 0;
      repeat (hold) @(negedge clk);
      rx_req = 1'b0;
      t = 0;
      while (m_rx_ack && t < 200) begin @(negedge clk); t++; end
      if (m_rx_ack) n_tmo++;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((m_busy || m_tx_req || tx_ack || m_rx_ack || tw_done) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 5000) n_tmo++;
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_logs();
      st_q.delete();
      tx_q.delete();
      rd_q.delete();
   endtask

   initial begin
      int s0;
      int t;

      // ---- reset values
      @(negedge clk);
      check("rst_vals", {a_rx_ack, a_rx_en, a_tx_req, a_tx_data, a_tw_start, a_tw_rnw,
                         a_tw_addr, a_tw_wdata, a_busy, a_err},
                        {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
      check("rst_vals16", {b_rx_en, b_tx_req, b_tw_wdata, b_busy, b_err},
                          {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ---- single write
      sel = 0; clear_logs(); s0 = n_start;
      send_byte(8'h00, 1'b0);
      check("wr_busy", m_busy, 1'b1);
      send_byte(8'h12, 1'b0);
      send_byte(8'hAB, 1'b1);
      wait_idle();
      check("wr_nstart", n_start - s0, 1);
      check("wr_xfer", st_q[0], {1'b0, 16'h0012, 16'h00AB});
      check("wr_ntx", tx_q.size(), 1);
      check("wr_status", tx_q[0], 8'h5A);
      check("wr_idle", {m_busy, m_rx_en}, 2'b01);

      // ---- read burst with increment and address wrap
      clear_logs(); s0 = n_start;
      rd_q = '{16'h01, 16'h02, 16'h03};
      send_byte(8'hC2, 1'b0);
      send_byte(8'hFE, 1'b1);
      wait_idle();
      check("rd_nstart", n_start - s0, 3);
      check("rd_a0", st_q[0][32:16], {1'b1, 16'h00FE});
      check("rd_a1", st_q[1][32:16], {1'b1, 16'h00FF});
      check("rd_a2", st_q[2][32:16], {1'b1, 16'h0000});
      check("rd_tx", {tx_q.size(), tx_q[0], tx_q[1], tx_q[2]}, {32'd3, 8'h01, 8'h02, 8'h03});

      // ---- watchdog in GET_ADDR
      clear_logs(); s0 = n_start;
      send_byte(8'h00, 1'b0);
      repeat (80) @(negedge clk);
      check("wd_early", {m_err, m_busy}, 2'b01);
      repeat (40) @(negedge clk);
      check("wd_fire", {m_err, m_busy, m_rx_en}, 3'b101);
      // ---- watchdog in GET_DATA: partial word is not issued
      send_byte(8'h00, 1'b0);
      check("wd_clr", m_err, 1'b0);
      send_byte(8'h10, 1'b0);
      repeat (120) @(negedge clk);
      check("wd_data_fire", {m_err, m_busy}, 2'b10);
      check("wd_nostart", n_start - s0, 0);
      // next command clears err and works
      rd_q = '{16'h77};
      send_byte(8'h80, 1'b0);
      check("wd_clr2", m_err, 1'b0);
      send_byte(8'h33, 1'b0);
      wait_idle();
      check("wd_recover", {st_q[0][32:16], tx_q[0]}, {1'b1, 16'h0033, 8'h77});

      // ---- 16-bit data: write burst without increment, then a read
      sel = 1; clear_logs(); s0 = n_start;
      send_byte(8'h01, 1'b0);
      send_byte(8'h40, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b0);
      send_byte(8'h78, 1'b0);
      wait_idle();
      check("w16_nstart", n_start - s0, 2);
      check("w16_x0", st_q[0], {1'b0, 16'h0040, 16'h1234});
      check("w16_x1", st_q[1], {1'b0, 16'h0040, 16'h5678});
      check("w16_tx", {tx_q.size(), tx_q[0]}, {32'd1, 8'h5A});
      clear_logs();
      rd_q = '{16'hBEEF};
      send_byte(8'h80, 1'b0);
      send_byte(8'h09, 1'b0);
      wait_idle();
      check("r16_tx", {tx_q.size(), tx_q[0], tx_q[1]}, {32'd2, 8'hBE, 8'hEF});
      check("r16_addr", st_q[0][32:16], {1'b1, 16'h0009});

      // ---- handshake stress
      sel = 0; stress = 1'b1; clear_logs(); s0 = n_start;
      rd_q = '{16'h11, 16'h22, 16'h33, 16'h44};
      send_byte(8'hC3, 1'b0);
      send_byte(8'h05, 1'b0);
      wait_idle();
      check("st_rd_tx", {tx_q.size(), tx_q[0], tx_q[1], tx_q[2], tx_q[3]},
                        {16'd4, 8'h11, 8'h22, 8'h33, 8'h44});
      check("st_rd_a3", st_q[3][32:16], {1'b1, 16'h0008});
      clear_logs();
      send_byte(8'h42, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'hA1, 1'b0);
      send_byte(8'hB2, 1'b0);
      send_byte(8'hC3, 1'b0);
      wait_idle();
      check("st_wr_n", st_q.size(), 3);
      check("st_wr_x0", st_q[0], {1'b0, 16'h0020, 16'h00A1});
      check("st_wr_x2", st_q[2], {1'b0, 16'h0022, 16'h00C3});
      check("st_wr_tx", {tx_q.size(), tx_q[0]}, {32'd1, 8'h5A});
      stress = 1'b0;

      // ---- reset while waiting for the 3-wire transfer
      clear_logs(); s0 = n_start; done_dly = 30;
      send_byte(8'h80, 1'b0);
      send_byte(8'h44, 1'b0);
      t = 0;
      while (n_start == s0 && t < 100) begin @(negedge clk); t++; end
      if (n_start == s0) n_tmo++;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid", {a_rx_ack, a_rx_en, a_tx_req, a_tx_data, a_tw_start, a_tw_rnw,
                        a_tw_addr, a_tw_wdata, a_busy, a_err},
                       {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("rst_ignore_done", {m_busy, m_tx_req, 8'(tx_q.size())}, {1'b0, 1'b0, 8'd0});
      check("rst_nstart", n_start - s0, 1);
      done_dly = 2; clear_logs(); s0 = n_start;
      send_byte(8'h00, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      wait_idle();
      check("rst_new_pkt", {st_q[0], tx_q[0]}, {1'b0, 16'h0055, 16'h0066, 8'h5A});
      check("rst_new_n", n_start - s0, 1);

      // ---- protocol integrity over the whole run
      check("bounded_waits", n_tmo, 0);
      check("tx_stable", n_unstable, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
